if_stage: RTL and testbench

//   Instruction-fetch stage; drives if_pc/if_inst into the IF/ID pipeline register.

---
 rtl/if_stage.sv | 113 +++++++++++
 tb/tb_if_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches 32-bit words byte-by-byte over a shared
// memory port and caches them in a direct-mapped, one-word-per-line instruction cache.
module if_stage #(
    parameter int unsigned ICACHE_LINES = 64,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        branch_en,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stall_req
);

    localparam int unsigned IDX  = $clog2(ICACHE_LINES);
    localparam int unsigned TAGW = 30 - IDX;

    typedef enum logic {StFetch, StReady} state_e;

    state_e                  state_q, state_d;
    logic [31:0]             pc_q, pc_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [31:0]             inst_buf_q, inst_buf_d;
    logic [ICACHE_LINES-1:0] valid_q, valid_d;

    logic [TAGW-1:0]         cache_tag  [ICACHE_LINES];
    logic [31:0]             cache_data [ICACHE_LINES];

    logic [IDX-1:0]          idx;
    logic [TAGW-1:0]         tag;
    logic                    hit;
    logic                    inst_ok;
    logic                    fill;
    logic [31:0]             fill_word;

    assign idx       = pc_q[IDX+1:2];
    assign tag       = pc_q[31:IDX+2];
    assign hit       = (state_q == StFetch) && (cnt_q == 2'd0) && valid_q[idx] &&
                       (cache_tag[idx] == tag);
    assign inst_ok   = (state_q == StReady) || hit;
    assign fill_word = {mem_data, inst_buf_q[23:0]};

    // Outputs are forced to their idle values during the reset cycle.
    always_comb begin
        if_pc     = rst ? RESET_PC : pc_q;
        if_inst   = NOP_INST;
        if (!rst && inst_ok) begin
            if_inst = (state_q == StReady) ? inst_buf_q : cache_data[idx];
        end
        mem_req   = !rst && (state_q == StFetch) && !hit && !branch_en;
        mem_addr  = pc_q + {30'd0, cnt_q};
        stall_req = !rst && !inst_ok && !branch_en;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        inst_buf_d = inst_buf_q;
        valid_d    = valid_q;
        fill       = 1'b0;
        if (branch_en) begin
            // Redirect wins; any ack this cycle is dropped with the partial word.
            pc_d    = branch_target;
            state_d = StFetch;
            cnt_d   = 2'd0;
        end else if (inst_ok && !stall_in) begin
            pc_d    = pc_q + 32'd4;
            state_d = StFetch;
            cnt_d   = 2'd0;
        end else if ((state_q == StFetch) && !hit && mem_ack) begin
            inst_buf_d[8*cnt_q +: 8] = mem_data;
            cnt_d                    = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                fill         = 1'b1;
                valid_d[idx] = 1'b1;
                state_d      = StReady;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            cnt_q      <= 2'd0;
            inst_buf_q <= 32'd0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            inst_buf_q <= inst_buf_d;
            valid_q    <= valid_d;
        end
    end

    // Tag/data arrays need no reset: valid bits gate every read.
    always_ff @(posedge clk) begin
        if (fill && !rst) begin
            cache_tag[idx]  <= tag;
            cache_data[idx] <= fill_word;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomised bench for if_stage against a word-level fetch model with a line-address cache.
module tb_if_stage;

    localparam int unsigned LINES    = 8;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall_in, branch_en, mem_ack, mem_req, stall_req;
    logic [31:0] branch_target, mem_addr, if_pc, if_inst;
    logic [7:0]  mem_data;

    int n_checks = 0;
    int n_errors = 0;

    // Model: current pc, bytes received for it (4 = instruction ready), cache of line addresses.
    logic [31:0] m_pc   = RST_PC;
    int          m_acks = 0;
    bit          m_valid [LINES];
    logic [31:0] m_line  [LINES];

    if_stage #(
        .ICACHE_LINES (LINES),
        .RESET_PC     (RST_PC),
        .NOP_INST     (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_in      (stall_in),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .stall_req     (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: begin
                h = a * 32'h9E37_79B1;
                return h[31:24] ^ a[7:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
    endfunction

    // One clock cycle: drive inputs, answer memory, compare outputs, advance the model.
    task automatic step(input logic r, input logic st, input logic br, input logic [31:0] tgt,
                        input int unsigned ack_pct);
        int          idx;
        logic        hit, ok, exp_req, exp_stall;
        logic [31:0] exp_addr, exp_inst, exp_pc;
        @(negedge clk);
        rst = r; stall_in = st; branch_en = br; branch_target = tgt;
        mem_ack = 1'b0; mem_data = 8'h00;
        idx      = int'((m_pc >> 2) % LINES);
        hit      = (m_acks == 0) && m_valid[idx] && (m_line[idx] == m_pc);
        ok       = (m_acks == 4) || hit;
        exp_addr = m_pc + ((m_acks == 4) ? 32'd0 : 32'(m_acks));
        if (r) begin
            exp_req = 1'b0; exp_stall = 1'b0; exp_pc = RST_PC; exp_inst = NOP;
        end else begin
            exp_req   = !ok && !br;
            exp_stall = !ok && !br;
            exp_pc    = m_pc;
            exp_inst  = ok ? word_at(m_pc) : NOP;
        end
        if (!r && (exp_req || br) && ($urandom_range(99) < ack_pct)) begin
            mem_ack  = 1'b1;
            mem_data = mem_byte(exp_addr);
        end
        #1;
        check("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
        check("stall_req", {31'd0, stall_req}, {31'd0, exp_stall});
        check("if_pc", if_pc, exp_pc);
        check("if_inst", if_inst, exp_inst);
        if (exp_req) check("mem_addr", mem_addr, exp_addr);
        if (r) begin
            m_pc = RST_PC; m_acks = 0;
            for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        end else if (br) begin
            m_pc = tgt; m_acks = 0;
        end else if (ok && !st) begin
            m_pc = m_pc + 32'd4; m_acks = 0;
        end else if (!ok && mem_ack) begin
            m_acks++;
            if (m_acks == 4) begin
                m_valid[idx] = 1'b1;
                m_line[idx]  = m_pc;
            end
        end
    endtask

    task automatic fill4();
        repeat (4) step(1'b0, 1'b1, 1'b0, 32'd0, 100);
    endtask

    initial begin
        logic [31:0] pool [7];
        int          reads;
        logic [31:0] tgt;
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_line[i]  = 32'd0;
        end
        pool = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h100 + 4 * LINES, 32'hFFFF_FFFC, 32'h40};

        // Reset, then acks every other cycle: eight stall cycles before the word appears.
        step(1'b1, 1'b0, 1'b0, 32'd0, 0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'd0, (i % 2) ? 100 : 0);
        step(1'b0, 1'b1, 1'b0, 32'd0, 0);
        check("t1_inst", if_inst, 32'h0010_0513);
        check("t1_stall", {31'd0, stall_req}, 32'd0);

        // Held while stalled, then consumed.
        repeat (4) step(1'b0, 1'b1, 1'b0, 32'd0, 0);
        check("t3_pc_hold", if_pc, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 0);
        fill4();
        step(1'b0, 1'b0, 1'b1, 32'd0, 0);
        step(1'b0, 1'b1, 1'b0, 32'd0, 0);
        check("t2_hit_req", {31'd0, mem_req}, 32'd0);
        check("t2_hit_inst", if_inst, 32'h0010_0513);

        // Redirect coincident with the third byte of pc 8.
        step(1'b0, 1'b0, 1'b0, 32'd0, 0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 0);
        step(1'b0, 1'b1, 1'b0, 32'd0, 100);
        step(1'b0, 1'b1, 1'b0, 32'd0, 100);
        step(1'b0, 1'b1, 1'b1, 32'h100, 100);
        step(1'b0, 1'b1, 1'b0, 32'd0, 0);
        check("t4_addr", mem_addr, 32'h100);
        fill4();
        step(1'b0, 1'b1, 1'b1, 32'h8, 0);
        step(1'b0, 1'b1, 1'b0, 32'd0, 0);
        check("t4_miss8", {31'd0, stall_req}, 32'd1);

        // Reset mid-fetch invalidates everything.
        step(1'b0, 1'b1, 1'b0, 32'd0, 100);
        step(1'b0, 1'b1, 1'b0, 32'd0, 100);
        step(1'b1, 1'b0, 1'b0, 32'd0, 0);
        step(1'b0, 1'b1, 1'b0, 32'd0, 0);
        check("t5_addr", mem_addr, RST_PC);
        check("t5_miss", {31'd0, stall_req}, 32'd1);

        // Conflicting lines evict each other.
        step(1'b0, 1'b1, 1'b1, 32'h100, 0);
        fill4();
        step(1'b0, 1'b1, 1'b1, 32'h100 + 4 * LINES, 0);
        fill4();
        step(1'b0, 1'b1, 1'b1, 32'h100, 0);
        reads = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'd0, 100);
            if (mem_ack) reads++;
        end
        check("t6_reads", 32'(reads), 32'd4);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            tgt = ($urandom_range(3) == 0) ? ($urandom() & 32'h0000_03FC)
                                           : pool[$urandom_range(6)];
            step($urandom_range(99) < 1, $urandom_range(99) < 20, $urandom_range(99) < 8, tgt,
                 60);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
